systolic_mm_core: RTL and testbench

SYSTOLIC_MM_CORE -- requirements
Module: systolic_mm_core

---
 rtl/systolic_mm_pkg.sv | 22 ++
 rtl/systolic_mm_if.sv | 33 +++
 rtl/systolic_mm_pe.sv | 38 +++
 rtl/systolic_mm_core.sv | 154 +++++++++++++++
 tb/tb_systolic_mm_core.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/systolic_mm_pkg.sv
// Shared types and size helpers for the N x N systolic matrix-multiply core.
package systolic_mm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      FEED,
      WRITE,
      FIN
   } state_t;

   // Width of a signed dot product of n terms of dw x dw signed products.
   function automatic int acc_width(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

   // Skewed injection lasts until the far-corner PE has seen its last pair.
   function automatic int feed_len(input int n);
      return 3 * n - 2;
   endfunction

endpackage

// File: rtl/systolic_mm_if.sv
// Operand load, control and result streaming bus of systolic_mm_core.
interface systolic_mm_if #(
   parameter int N  = 8,
   parameter int DW = 8
);
   localparam int AW    = systolic_mm_pkg::acc_width(N, DW);
   localparam int ADDRW = $clog2(N * N);

   logic                    ld_valid;
   logic                    ld_ready;
   logic                    ld_sel;
   logic [ADDRW-1:0]        ld_addr;
   logic signed [DW-1:0]    ld_data;
   logic                    start;
   logic                    busy;
   logic                    done;
   logic                    c_valid;
   logic                    c_ready;
   logic [ADDRW-1:0]        c_addr;
   logic signed [AW-1:0]    c_data;
   logic [15:0]             cyc_count;

   modport master (
      output ld_valid, ld_sel, ld_addr, ld_data, start, c_ready,
      input  ld_ready, busy, done, c_valid, c_addr, c_data, cyc_count
   );

   modport slave (
      input  ld_valid, ld_sel, ld_addr, ld_data, start, c_ready,
      output ld_ready, busy, done, c_valid, c_addr, c_data, cyc_count
   );

endinterface

// File: rtl/systolic_mm_pe.sv
// Processing element: signed MAC with east/south operand forwarding registers.
module systolic_mm_pe #(
   parameter int DW = 8,
   parameter int AW = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 en,
   input  logic signed [DW-1:0] a_in,
   input  logic signed [DW-1:0] b_in,
   output logic signed [DW-1:0] a_out,
   output logic signed [DW-1:0] b_out,
   output logic signed [AW-1:0] acc
);

   logic signed [2*DW-1:0] prod_p0;

   assign prod_p0 = a_in * b_in;

   // p0 -> p1: product folds into the accumulator, operands move on
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (clr) begin
         a_out <= '0;
         b_out <= '0;
         acc   <= '0;
      end else if (en) begin
         a_out <= a_in;
         b_out <= b_in;
         acc   <= acc + AW'(prod_p0);
      end
   end

endmodule

// File: rtl/systolic_mm_core.sv
// N x N output-stationary systolic multiplier C = A x B with streamed result readout.
// Optional cycle counter enabled by defining SYSTOLIC_MM_CYCLE_CNT_EN.
module systolic_mm_core
   import systolic_mm_pkg::*;
#(
   parameter int N  = 8,
   parameter int DW = 8
) (
   input  logic         clk,
   input  logic         rst,
   systolic_mm_if.slave bus
);

   localparam int AW       = acc_width(N, DW);
   localparam int ADDRW    = $clog2(N * N);
   localparam int FEED_LEN = feed_len(N);
   localparam int KW       = $clog2(FEED_LEN);

   state_t               state;
   logic [KW-1:0]        k;
   logic [ADDRW-1:0]     c_addr_q;
   logic                 c_valid_q;
   logic                 done_q;
   logic                 busy_q;
   logic                 ld_ready_q;
   logic                 pe_clr;
   logic                 pe_en;

   logic signed [DW-1:0] a_buf [N*N];
   logic signed [DW-1:0] b_buf [N*N];
   logic signed [DW-1:0] a_h   [N][N+1];
   logic signed [DW-1:0] b_v   [N+1][N];
   logic signed [AW-1:0] acc   [N*N];

   assign pe_clr = (state == CLEAR);
   assign pe_en  = (state == FEED);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N * N; i++) begin
            a_buf[i] <= '0;
            b_buf[i] <= '0;
         end
      end else if (bus.ld_valid && ld_ready_q) begin
         if (bus.ld_sel) b_buf[bus.ld_addr] <= bus.ld_data;
         else            a_buf[bus.ld_addr] <= bus.ld_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         k          <= '0;
         c_addr_q   <= '0;
         c_valid_q  <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ld_ready_q <= 1'b1;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               state      <= CLEAR;
               busy_q     <= 1'b1;
               ld_ready_q <= 1'b0;
            end
            CLEAR: begin
               state <= FEED;
               k     <= '0;
            end
            FEED: if (k == KW'(FEED_LEN - 1)) begin
               state     <= WRITE;
               c_addr_q  <= '0;
               c_valid_q <= 1'b1;
            end else begin
               k <= k + 1'b1;
            end
            WRITE: if (bus.c_ready) begin
               if (c_addr_q == ADDRW'(N * N - 1)) begin
                  state     <= FIN;
                  c_valid_q <= 1'b0;
                  done_q    <= 1'b1;
               end else begin
                  c_addr_q <= c_addr_q + 1'b1;
               end
            end
            FIN: begin
               state      <= IDLE;
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               ld_ready_q <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Skewed edge injection: row i lags by i cycles, column j by j cycles.
   for (genvar gi = 0; gi < N; gi++) begin : g_inj
      logic             in_win;
      logic [ADDRW-1:0] a_idx;
      logic [ADDRW-1:0] b_idx;
      assign in_win      = pe_en && (int'(k) >= gi) && (int'(k) < gi + N);
      assign a_idx       = ADDRW'(gi * N + int'(k) - gi);
      assign b_idx       = ADDRW'((int'(k) - gi) * N + gi);
      assign a_h[gi][0]  = in_win ? a_buf[a_idx] : '0;
      assign b_v[0][gi]  = in_win ? b_buf[b_idx] : '0;
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         systolic_mm_pe #(.DW(DW), .AW(AW)) u_pe (
            .clk   (clk),
            .rst   (rst),
            .clr   (pe_clr),
            .en    (pe_en),
            .a_in  (a_h[gi][gj]),
            .b_in  (b_v[gi][gj]),
            .a_out (a_h[gi][gj+1]),
            .b_out (b_v[gi+1][gj]),
            .acc   (acc[gi*N+gj])
         );
      end
   end

   assign bus.ld_ready = ld_ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.c_valid  = c_valid_q;
   assign bus.c_addr   = c_addr_q;
   assign bus.c_data   = c_valid_q ? acc[c_addr_q] : '0;

`ifdef SYSTOLIC_MM_CYCLE_CNT_EN
   logic [15:0] cyc_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cyc_q <= '0;
      end else if (state == IDLE) begin
         if (bus.start) cyc_q <= '0;
      end else begin
         cyc_q <= sat_inc(cyc_q);
      end
   end

   assign bus.cyc_count = cyc_q;
`else
   assign bus.cyc_count = '0;
`endif

endmodule

// File: tb/tb_systolic_mm_core.sv
// Scoreboard bench for systolic_mm_core: N=8/DW=8 and N=4/DW=4 instances.
module tb_systolic_mm_core;
   import systolic_mm_pkg::*;

   localparam int N   = 8;
   localparam int DW  = 8;
   localparam int AW  = acc_width(N, DW);
   localparam int N4  = 4;
   localparam int DW4 = 4;
   localparam int AW4 = acc_width(N4, DW4);
`ifdef SYSTOLIC_MM_CYCLE_CNT_EN
   localparam int CYC_EXP = 1 + (3 * N - 2) + N * N + 1;
`else
   localparam int CYC_EXP = 0;
`endif

   typedef struct {
      int addr;
      int data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   ma [N*N];
   int   mb [N*N];
   int   a4 [N4*N4];
   int   b4 [N4*N4];
   exp_t sbq [$];

   always #5 clk = ~clk;

   systolic_mm_if #(.N(N),  .DW(DW))  bif ();
   systolic_mm_if #(.N(N4), .DW(DW4)) bif4 ();

   systolic_mm_core #(.N(N),  .DW(DW))  dut  (.clk(clk), .rst(rst), .bus(bif));
   systolic_mm_core #(.N(N4), .DW(DW4)) dut4 (.clk(clk), .rst(rst), .bus(bif4));

   task automatic load8(input bit start_last);
      for (int s = 0; s < 2; s++) begin
         for (int idx = 0; idx < N * N; idx++) begin
            @(negedge clk);
            bif.ld_valid = 1'b1;
            bif.ld_sel   = (s == 1);
            bif.ld_addr  = 6'(idx);
            bif.ld_data  = DW'((s == 0) ? ma[idx] : mb[idx]);
            if (start_last && s == 1 && idx == N * N - 1) bif.start = 1'b1;
         end
      end
      @(negedge clk);
      bif.ld_valid = 1'b0;
      bif.start    = 1'b0;
   endtask

   // mode 0: c_ready always high; mode 1: c_ready alternates during WRITE
   task automatic run8(input bit do_start, input int mode, input bit inject, input int exp_cyc);
      exp_t e;
      int   beats = 0;
      int   cyc = 0;
      bit   got_done = 0;
      bit   held = 0;
      int   h_addr = 0;
      int   h_data = 0;
      bit   rdy;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++) begin
            e.addr = i * N + j;
            e.data = 0;
            for (int t = 0; t < N; t++) e.data += ma[i*N+t] * mb[t*N+j];
            sbq.push_back(e);
         end
      bif.c_ready = 1'b1;
      if (do_start) begin
         @(negedge clk);
         bif.start = 1'b1;
         @(negedge clk);
         bif.start = 1'b0;
      end
      n_checks++;
      if (bif.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_after_start got=%b want=1", bif.busy);
      end
      while (!got_done && cyc < 500) begin
         @(negedge clk);
         cyc++;
         if (inject && cyc == 4) begin
            n_checks++;
            if (bif.ld_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL ld_ready_busy got=%b want=0", bif.ld_ready);
            end
            bif.start    = 1'b1;
            bif.ld_valid = 1'b1;
            bif.ld_sel   = 1'b0;
            bif.ld_addr  = '0;
            bif.ld_data  = DW'((ma[0] == 77) ? 78 : 77);
         end else if (inject && cyc == 5) begin
            bif.start    = 1'b0;
            bif.ld_valid = 1'b0;
         end
         if (held) begin
            n_checks++;
            if (int'(bif.c_addr) !== h_addr || int'(bif.c_data) !== h_data) begin
               n_fail++;
               $display("FAIL stall_hold got=%0d/%0d want=%0d/%0d",
                        bif.c_addr, bif.c_data, h_addr, h_data);
            end
            held = 0;
         end
         if (bif.done) begin
            got_done = 1;
            n_checks++;
            if (sbq.size() != 0) begin
               n_fail++;
               $display("FAIL done_early remaining=%0d want=0", sbq.size());
            end
         end else if (bif.c_valid) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            bif.c_ready = rdy;
            n_checks++;
            if (sbq.size() == 0) begin
               n_fail++;
               $display("FAIL extra_beat c_addr=%0d want=none", bif.c_addr);
            end else begin
               e = sbq[0];
               if (int'(bif.c_addr) !== e.addr || int'(bif.c_data) !== e.data) begin
                  n_fail++;
                  $display("FAIL c_elem got=%0d/%0d want=%0d/%0d",
                           bif.c_addr, bif.c_data, e.addr, e.data);
               end
               if (rdy) begin
                  void'(sbq.pop_front());
                  beats++;
               end else begin
                  held   = 1;
                  h_addr = int'(bif.c_addr);
                  h_data = int'(bif.c_data);
               end
            end
         end
      end
      n_checks++;
      if (!got_done || beats != N * N) begin
         n_fail++;
         $display("FAIL done_or_beats done=%b beats=%0d want=1/%0d", got_done, beats, N * N);
      end
      sbq.delete();
      bif.c_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bif.busy !== 1'b0 || bif.ld_ready !== 1'b1 || bif.done !== 1'b0) begin
         n_fail++;
         $display("FAIL post_idle busy/ld_ready/done got=%b%b%b want=010",
                  bif.busy, bif.ld_ready, bif.done);
      end
`ifdef SYSTOLIC_MM_CYCLE_CNT_EN
      if (exp_cyc >= 0) begin
         n_checks++;
         if (int'(bif.cyc_count) !== exp_cyc) begin
            n_fail++;
            $display("FAIL cyc_count got=%0d want=%0d", bif.cyc_count, exp_cyc);
         end
      end
`else
      n_checks++;
      if (bif.cyc_count !== 16'd0) begin
         n_fail++;
         $display("FAIL cyc_count got=%0d want=0 (exp %0d)", bif.cyc_count, exp_cyc);
      end
`endif
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_checks++;
      if (bif.busy !== 1'b0 || bif.ld_ready !== 1'b1 || bif.done !== 1'b0 ||
          bif.c_valid !== 1'b0 || bif.c_addr !== '0 || bif.c_data !== '0 ||
          bif.cyc_count !== '0) begin
         n_fail++;
         $display("FAIL reset8 busy=%b rdy=%b done=%b cv=%b ca=%0d cd=%0d cyc=%0d want 0,1,0,0,0,0,0",
                  bif.busy, bif.ld_ready, bif.done, bif.c_valid, bif.c_addr, bif.c_data, bif.cyc_count);
      end
      n_checks++;
      if (bif4.busy !== 1'b0 || bif4.ld_ready !== 1'b1 || bif4.c_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset4 busy=%b rdy=%b cv=%b want 0,1,0", bif4.busy, bif4.ld_ready, bif4.c_valid);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_identity();
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            ma[r*N+c] = (r == c) ? 1 : 0;
            mb[r*N+c] = r * N + c;
         end
      load8(1'b0);
      run8(1'b1, 0, 1'b0, CYC_EXP);
   endtask

   task automatic test_repeat();
      run8(1'b1, 0, 1'b0, CYC_EXP);
   endtask

   task automatic test_minus128();
      for (int i = 0; i < N * N; i++) begin
         ma[i] = -128;
         mb[i] = -128;
      end
      load8(1'b1);
      run8(1'b0, 0, 1'b0, CYC_EXP);
   endtask

   task automatic test_stall();
      for (int i = 0; i < N * N; i++) begin
         ma[i] = int'($urandom_range(255)) - 128;
         mb[i] = int'($urandom_range(255)) - 128;
      end
      load8(1'b0);
      run8(1'b1, 1, 1'b0, -1);
   endtask

   task automatic test_feed_ignore();
      run8(1'b1, 0, 1'b1, CYC_EXP);
   endtask

   task automatic test_reset_mid();
      bit saw_done = 0;
      for (int i = 0; i < N * N; i++) begin
         ma[i] = (i % 7) - 3;
         mb[i] = (i % 5) + 1;
      end
      load8(1'b0);
      @(negedge clk);
      bif.start = 1'b1;
      @(negedge clk);
      bif.start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bif.busy !== 1'b0 || bif.ld_ready !== 1'b1 || bif.c_valid !== 1'b0 ||
          bif.done !== 1'b0 || bif.cyc_count !== '0) begin
         n_fail++;
         $display("FAIL reset_mid busy=%b rdy=%b cv=%b done=%b cyc=%0d want 0,1,0,0,0",
                  bif.busy, bif.ld_ready, bif.c_valid, bif.done, bif.cyc_count);
      end
      rst = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (bif.done) saw_done = 1;
      end
      n_checks++;
      if (saw_done) begin
         n_fail++;
         $display("FAIL reset_mid_done got=1 want=0");
      end
      for (int i = 0; i < N * N; i++) begin
         ma[i] = 0;
         mb[i] = 0;
      end
      run8(1'b1, 0, 1'b0, CYC_EXP);
      for (int i = 0; i < N * N; i++) begin
         ma[i] = int'($urandom_range(255)) - 128;
         mb[i] = int'($urandom_range(255)) - 128;
      end
      load8(1'b0);
      run8(1'b1, 0, 1'b0, CYC_EXP);
   endtask

   task automatic test_random4();
      exp_t e;
      int   cyc;
      int   beats;
      bit   got_done;
      bit   rdy;
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < N4 * N4; i++) begin
            a4[i] = (round == 0) ? -8 : int'($urandom_range(15)) - 8;
            b4[i] = (round == 0) ? -8 : int'($urandom_range(15)) - 8;
         end
         for (int s = 0; s < 2; s++)
            for (int idx = 0; idx < N4 * N4; idx++) begin
               @(negedge clk);
               bif4.ld_valid = 1'b1;
               bif4.ld_sel   = (s == 1);
               bif4.ld_addr  = 4'(idx);
               bif4.ld_data  = DW4'((s == 0) ? a4[idx] : b4[idx]);
            end
         for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++) begin
               e.addr = i * N4 + j;
               e.data = 0;
               for (int t = 0; t < N4; t++) e.data += a4[i*N4+t] * b4[t*N4+j];
               sbq.push_back(e);
            end
         @(negedge clk);
         bif4.ld_valid = 1'b0;
         bif4.start    = 1'b1;
         @(negedge clk);
         bif4.start = 1'b0;
         cyc = 0;
         beats = 0;
         got_done = 0;
         while (!got_done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bif4.done) begin
               got_done = 1;
            end else if (bif4.c_valid) begin
               rdy = 1'($urandom_range(1));
               bif4.c_ready = rdy;
               n_checks++;
               if (sbq.size() == 0) begin
                  n_fail++;
                  $display("FAIL n4_extra_beat c_addr=%0d want=none", bif4.c_addr);
               end else begin
                  e = sbq[0];
                  if (int'(bif4.c_addr) !== e.addr || int'(bif4.c_data) !== e.data) begin
                     n_fail++;
                     $display("FAIL n4_c_elem got=%0d/%0d want=%0d/%0d",
                              bif4.c_addr, bif4.c_data, e.addr, e.data);
                  end
                  if (rdy) begin
                     void'(sbq.pop_front());
                     beats++;
                  end
               end
            end
         end
         n_checks++;
         if (!got_done || beats != N4 * N4) begin
            n_fail++;
            $display("FAIL n4_done_or_beats done=%b beats=%0d want=1/%0d", got_done, beats, N4 * N4);
         end
         sbq.delete();
         bif4.c_ready = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      bif.ld_valid  = 1'b0;
      bif.ld_sel    = 1'b0;
      bif.ld_addr   = '0;
      bif.ld_data   = '0;
      bif.start     = 1'b0;
      bif.c_ready   = 1'b1;
      bif4.ld_valid = 1'b0;
      bif4.ld_sel   = 1'b0;
      bif4.ld_addr  = '0;
      bif4.ld_data  = '0;
      bif4.start    = 1'b0;
      bif4.c_ready  = 1'b1;
      test_reset();
      test_identity();
      test_repeat();
      test_minus128();
      test_stall();
      test_feed_ignore();
      test_reset_mid();
      test_random4();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
